// File: rtl/sio_pkg.sv
// Shared types and default geometry for the SIO serial transmitter.
package sio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } sio_state_e;

  localparam int SIO_WIDTH_DEF  = 10;
  localparam int SIO_CLKDIV_DEF = 4;

endpackage

// File: rtl/sio_half_timer.sv
// Loadable down-counter timing one SioClk half-period of CLKDIV MCLK cycles.
module sio_half_timer #(
  parameter int CLKDIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CW = $clog2(CLKDIV + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = LOAD_VAL;
    else if (run_i && cnt_q != '0) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Loaded with CLKDIV-1 on phase entry, so the tick lands on the CLKDIV-th cycle.
  assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/sio_shift_tx.sv
// SIO transmitter: serialises a parallel word LSB first on SioDat, clocked by a divided SioClk.
module sio_shift_tx
  import sio_pkg::*;
#(
  parameter int WIDTH  = SIO_WIDTH_DEF,
  parameter int CLKDIV = SIO_CLKDIV_DEF
) (
  input  logic             MCLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] TxData,
  input  logic             TxStart,
  output logic             TxBusy,
  output logic             TxDone,
  output logic             SioClk,
  output logic             SioDat
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  sio_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic             clk_q, clk_d, dat_q, dat_d, busy_q, busy_d, done_q, done_d;
  logic             accept, expire, last_bit, tmr_load, tmr_run;

  // DONE is treated as idle so a new frame can start right on the TxDone cycle.
  assign accept   = (state_q == ST_IDLE || state_q == ST_DONE) && TxStart;
  assign last_bit = (bits_q == LAST_BIT);
  assign tmr_run  = (state_q == ST_LOW || state_q == ST_HIGH);
  assign tmr_load = (state_d != state_q) && (state_d == ST_LOW || state_d == ST_HIGH);

  sio_half_timer #(.CLKDIV(CLKDIV)) u_timer (
    .clk_i    (MCLK),
    .rst_i    (RESET),
    .load_i   (tmr_load),
    .run_i    (tmr_run),
    .expire_o (expire)
  );

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: state_d = TxStart ? ST_LOW : ST_IDLE;
      ST_LOW:           if (expire) state_d = ST_HIGH;
      ST_HIGH:          if (expire) state_d = last_bit ? ST_DONE : ST_LOW;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clk_d  = 1'b0;
    dat_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      ST_LOW: begin
        busy_d = 1'b1;
        // Data only moves on the falling edge; hold it through the rest of LOW.
        if (accept)                 dat_d = TxData[0];
        else if (state_q == ST_HIGH) dat_d = shift_q[1];
        else                         dat_d = dat_q;
      end
      ST_HIGH: begin
        busy_d = 1'b1;
        clk_d  = 1'b1;
        dat_d  = dat_q;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    bits_d  = bits_q;
    if (accept) begin
      shift_d = TxData;
      bits_d  = '0;
    end else if (state_q == ST_HIGH && state_d == ST_LOW) begin
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
      bits_d  = bits_q + BW'(1);
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      shift_q <= '0;
      bits_q  <= '0;
      clk_q   <= 1'b0;
      dat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bits_q  <= bits_d;
      clk_q   <= clk_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TxBusy = busy_q;
  assign TxDone = done_q;
  assign SioClk = clk_q;
  assign SioDat = dat_q;

endmodule

// File: tb/tb_sio_shift_tx.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor checks each TxDone.
module tb_sio_shift_tx;

  logic MCLK = 1'b0;
  logic rst  = 1'b1;
  always #5 MCLK = ~MCLK;

  logic [1:0]      start = '0;
  logic [1:0]      busy, done, sclk, sdat;
  logic [1:0][9:0] data = '0;

  sio_shift_tx #(.WIDTH(10), .CLKDIV(4)) u0 (
    .MCLK(MCLK), .RESET(rst), .TxData(data[0]), .TxStart(start[0]),
    .TxBusy(busy[0]), .TxDone(done[0]), .SioClk(sclk[0]), .SioDat(sdat[0]));

  sio_shift_tx #(.WIDTH(10), .CLKDIV(1)) u1 (
    .MCLK(MCLK), .RESET(rst), .TxData(data[1]), .TxStart(start[1]),
    .TxBusy(busy[1]), .TxDone(done[1]), .SioClk(sclk[1]), .SioDat(sdat[1]));

  typedef struct {
    int         id;
    logic [9:0] w;
    int         acc;
    int         rs;
  } exp_t;

  exp_t sb[$];
  exp_t em;
  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   ndone[2] = '{0, 0};
  int   last_done[2] = '{0, 0};
  logic [1:0] pdat = '0;

  always @(posedge MCLK) cyc <= cyc + 1;

  // Receiver models
  logic [9:0] r0 = '0, r1 = '0;
  int         rs0 = 0, rs1 = 0;
  always @(posedge sclk[0]) begin r0 <= {sdat[0], r0[9:1]}; rs0 <= rs0 + 1; end
  always @(posedge sclk[1]) begin r1 <= {sdat[1], r1[9:1]}; rs1 <= rs1 + 1; end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge MCLK) begin
    for (int i = 0; i < 2; i++) begin
      if (sclk[i]) chk("dat_stable_while_clk_high", int'(sdat[i]), int'(pdat[i]));
      if (!busy[i] && !done[i]) begin
        chk("idle_sioclk_low", int'(sclk[i]), 0);
        chk("idle_siodat_low", int'(sdat[i]), 0);
      end
      pdat[i] = sdat[i];
      if (done[i]) begin
        ndone[i]++;
        last_done[i] = cyc;
        if (sb.size() == 0 || sb[0].id != i) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txdone: dut %0d pulsed TxDone, none expected", i);
        end else begin
          em = sb.pop_front();
          chk("rx_word", (i == 0) ? int'(r0) : int'(r1), int'(em.w));
          chk("sioclk_rises", ((i == 0) ? rs0 : rs1) - em.rs, 10);
          chk("frame_len", cyc - em.acc, (i == 0) ? 80 : 20);
        end
      end
    end
  end

  task automatic send(input int i, input logic [9:0] w, output int acc);
    int   n = 0;
    exp_t e;
    @(negedge MCLK);
    while (busy[i] && n < 400) begin @(negedge MCLK); n++; end
    if (busy[i]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: dut %0d still busy after %0d cycles", i, n);
    end
    data[i]  = w;
    start[i] = 1'b1;
    @(posedge MCLK);
    #1;
    acc   = cyc;
    e.id  = i;
    e.w   = w;
    e.acc = cyc;
    e.rs  = (i == 0) ? rs0 : rs1;
    sb.push_back(e);
    start[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin @(negedge MCLK); n++; end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d frames outstanding", sb.size());
    end
    repeat (3) @(negedge MCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, nd0;
    repeat (2) @(negedge MCLK);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_sioclk", int'(sclk[i]), 0);
      chk("rst_siodat", int'(sdat[i]), 0);
    end
    rst = 1'b0;

    // single frame
    send(0, 10'h2A5, a);
    wait_idle();

    // back-to-back, second start lands on the TxDone cycle
    send(0, 10'h3FF, a);
    send(0, 10'h001, b);
    chk("b2b_gap", b - last_done[0], 1);
    wait_idle();

    // mid-frame TxStart/TxData change is ignored
    nd0 = ndone[0];
    send(0, 10'h19A, a);
    repeat (19) @(posedge MCLK);
    #1;
    data[0]  = 10'h3C3;
    start[0] = 1'b1;
    @(posedge MCLK);
    #1;
    start[0] = 1'b0;
    wait_idle();
    chk("one_txdone_only", ndone[0] - nd0, 1);

    // async reset mid-frame (cycle 37 falls in a HIGH phase)
    send(0, 10'h2AA, a);
    repeat (37) @(posedge MCLK);
    #1;
    chk("busy_before_rst", int'(busy[0]), 1);
    chk("clk_high_before_rst", int'(sclk[0]), 1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_sioclk", int'(sclk[0]), 0);
    chk("midrst_siodat", int'(sdat[0]), 0);
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_done", int'(done[0]), 0);
    sb.delete();
    repeat (2) @(negedge MCLK);
    rst = 1'b0;
    send(0, 10'h0F0, a);
    wait_idle();

    // CLKDIV=1 instance
    send(1, 10'h155, a);
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    chk("txdone_count_dut0", ndone[0], 5);
    chk("txdone_count_dut1", ndone[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
